// File: rtl/wb_spi_slave_fifo.sv
// 8-bit synchronous byte FIFO with clear; head is visible combinationally, size updates the cycle after push/pop/clear.
// Push when full and pop when empty are ignored; clear wins over a same-cycle push or pop.
module wb_spi_slave_fifo #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  push_dat_i,
    input  logic        pop_i,
    output logic [7:0]  head_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [15:0] size_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign size_o  = 16'(count_q);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~clear_i;
    assign do_pop  = pop_i & ~empty_o & ~clear_i;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: emptiness is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

// File: rtl/wb_spi_slave.sv
// SPI slave (all cpol/cpha modes) bridged to Wishbone through TX/RX byte FIFOs; sclk pin to miso in at most 4 clk.
// Wishbone access stalls (no ack) on TX full / RX empty; RX bytes arriving while RX is full are dropped.
module wb_spi_slave #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        tx_clear,
    input  logic        rx_clear,
    output logic [15:0] tx_size,
    output logic [15:0] rx_size,
    input  logic [7:0]  dat_i,
    output logic [7:0]  dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    output logic        ack_o
);
    logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic       sclk_prev_q, cs_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic       miso_q, miso_d;
    logic       ack_q, ack_d;
    logic [7:0] dat_q, dat_d;

    logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_avail;
    logic tx_pop, rx_push, wr_go, rd_go;
    logic [7:0] tx_head, rx_head, tx_load;

    assign sclk_s    = sclk_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    assign lead_edge   = cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;

    assign tx_avail = ~tx_empty & ~tx_clear;
    assign tx_load  = tx_avail ? tx_head : 8'h00;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        miso_d    = miso_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        if (cs_s) begin
            // Deselected: any partial byte and preloaded TX byte are abandoned.
            bit_cnt_d = '0;
            tx_sr_d   = '0;
            rx_sr_d   = '0;
            miso_d    = 1'b0;
        end else if (cs_fall) begin
            bit_cnt_d = '0;
            rx_sr_d   = '0;
            tx_sr_d   = tx_load;
            tx_pop    = tx_avail;
            miso_d    = cpha ? 1'b0 : tx_load[7];
        end else if (sample_edge) begin
            rx_sr_d   = {rx_sr_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                rx_push = 1'b1;
                tx_sr_d = tx_load;
                tx_pop  = tx_avail;
            end
        end else if (shift_edge) begin
            miso_d = tx_sr_q[~bit_cnt_q];
        end
    end

    assign wr_go = stb_i & we_i & ~ack_q & ~tx_full & ~tx_clear;
    assign rd_go = stb_i & ~we_i & ~ack_q & ~rx_empty & ~rx_clear;
    assign ack_d = wr_go | rd_go;
    assign dat_d = rd_go ? rx_head : dat_q;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            miso_q      <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            cs_sync_q   <= {cs_sync_q[0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            bit_cnt_q   <= bit_cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            miso_q      <= miso_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
        end
    end

    assign miso  = miso_q;
    assign ack_o = ack_q;
    assign dat_o = dat_q;

    wb_spi_slave_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk        (clk),
        .rstz       (rstz),
        .clear_i    (tx_clear),
        .push_i     (wr_go),
        .push_dat_i (dat_i),
        .pop_i      (tx_pop),
        .head_o     (tx_head),
        .full_o     (tx_full),
        .empty_o    (tx_empty),
        .size_o     (tx_size)
    );

    wb_spi_slave_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk        (clk),
        .rstz       (rstz),
        .clear_i    (rx_clear),
        .push_i     (rx_push),
        .push_dat_i ({rx_sr_q[6:0], mosi_s}),
        .pop_i      (rd_go),
        .head_o     (rx_head),
        .full_o     (rx_full),
        .empty_o    (rx_empty),
        .size_o     (rx_size)
    );

    // Occupancy is reported through rx_size; the full flag itself has no other consumer.
    logic unused_rx_full;
    assign unused_rx_full = rx_full;
endmodule

// File: tb/tb_wb_spi_slave.sv
// Directed bench for wb_spi_slave: bit-banged SPI master plus Wishbone byte reads/writes.
// Expected bytes come from the bench's own stimulus tables.
module tb_wb_spi_slave;
    localparam int DEPTH = 64;

    logic        clk = 1'b0, rstz = 1'b0;
    logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic        tx_clear = 1'b0, rx_clear = 1'b0, we_i = 1'b0, stb_i = 1'b0;
    logic [7:0]  dat_i = 8'h00;
    logic        miso, ack_o;
    logic [7:0]  dat_o;
    logic [15:0] tx_size, rx_size;

    int n_vec = 0;
    int n_bad = 0;

    wb_spi_slave #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstz(rstz), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .cpol(cpol), .cpha(cpha), .tx_clear(tx_clear), .rx_clear(rx_clear),
        .tx_size(tx_size), .rx_size(rx_size), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .stb_i(stb_i), .ack_o(ack_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wb_write(input logic [7:0] d);
        int t;
        stb_i = 1'b1; we_i = 1'b1; dat_i = d; t = 0;
        do begin @(negedge clk); t++; end while (!ack_o && t < 200);
        check("wb_write_ack", 32'(ack_o), 32'd1);
        stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_read(output logic [7:0] d);
        int t;
        stb_i = 1'b1; we_i = 1'b0; t = 0;
        do begin @(negedge clk); t++; end while (!ack_o && t < 200);
        check("wb_read_ack", 32'(ack_o), 32'd1);
        d = dat_o;
        stb_i = 1'b0;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cpol = pol; cpha = pha; sclk = pol;
        tick(8);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_end(input int hp);
        tick(hp);
        cs_n = 1'b1;
        tick(8);
    endtask

    // Master side: drives on its shift edge, samples miso on its sample edge.
    task automatic spi_byte(input logic [7:0] tx, input int hp, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi = tx[i]; tick(hp);
                rx[i] = miso; sclk = ~cpol; tick(hp);
                sclk = cpol;
            end else begin
                tick(hp);
                sclk = ~cpol; mosi = tx[i]; tick(hp);
                rx[i] = miso; sclk = cpol;
            end
        end
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] txb [32];
        logic [7:0] mb  [32];
        int n, hp;

        // Reset state
        tick(3);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_dat_o", 32'(dat_o), 32'h00);
        check("rst_tx_size", 32'(tx_size), 32'd0);
        check("rst_rx_size", 32'(rx_size), 32'd0);
        rstz = 1'b1;
        tick(2);

        // Mode 0 two-byte exchange
        set_mode(1'b0, 1'b0);
        wb_write(8'hA5);
        wb_write(8'h3C);
        check("m0_tx_size", 32'(tx_size), 32'd2);
        cs_begin();
        spi_byte(8'h5A, 8, 8, r); check("m0_miso0", 32'(r), 32'hA5);
        spi_byte(8'hC3, 8, 8, r); check("m0_miso1", 32'(r), 32'h3C);
        cs_end(8);
        check("m0_rx_size2", 32'(rx_size), 32'd2);
        check("m0_tx_size0", 32'(tx_size), 32'd0);
        wb_read(r); check("m0_rx0", 32'(r), 32'h5A);
        wb_read(r); check("m0_rx1", 32'(r), 32'hC3);
        check("m0_rx_size0", 32'(rx_size), 32'd0);

        // TX empty: slave returns 0x00
        cs_begin();
        spi_byte(8'h96, 7, 8, r); check("txempty_miso", 32'(r), 32'h00);
        cs_end(7);
        check("txempty_rx_size", 32'(rx_size), 32'd1);
        wb_read(r); check("txempty_rx", 32'(r), 32'h96);

        // Aborted partial byte, then a clean 0x81
        set_mode(1'b1, 1'b0);
        cs_begin();
        spi_byte(8'hFF, 6, 5, r);
        cs_end(6);
        check("abort_rx_size", 32'(rx_size), 32'd0);
        cs_begin();
        spi_byte(8'h81, 6, 8, r);
        cs_end(6);
        check("abort_new_rx_size", 32'(rx_size), 32'd1);
        wb_read(r); check("abort_new_rx", 32'(r), 32'h81);

        // All four modes, random payloads and sclk rates
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0]);
            n  = $urandom_range(1, 31);
            hp = $urandom_range(6, 16);
            for (int k = 0; k < n; k++) begin
                txb[k] = 8'($urandom);
                mb[k]  = 8'($urandom);
                wb_write(txb[k]);
            end
            cs_begin();
            for (int k = 0; k < n; k++) begin
                spi_byte(mb[k], hp, 8, r);
                check("rand_miso", 32'(r), 32'(txb[k]));
            end
            cs_end(hp);
            check("rand_rx_size", 32'(rx_size), 32'(n));
            for (int k = 0; k < n; k++) begin
                wb_read(r);
                check("rand_rx", 32'(r), 32'(mb[k]));
            end
        end

        // RX overflow: DEPTH bytes fill it, one more is dropped
        set_mode(1'b0, 1'b0);
        cs_begin();
        for (int k = 0; k < DEPTH; k++) spi_byte(8'(k * 3 + 1), 6, 8, r);
        spi_byte(8'hFF, 6, 8, r);
        cs_end(6);
        check("rxfull_size", 32'(rx_size), 32'(DEPTH));
        wb_read(r); check("rxfull_oldest", 32'(r), 32'h01);
        check("rxfull_size_after_read", 32'(rx_size), 32'(DEPTH - 1));
        rx_clear = 1'b1; tick(1); rx_clear = 1'b0;
        check("rx_clear_size", 32'(rx_size), 32'd0);

        // TX full stall, cleared by tx_clear, then the pending write completes
        for (int k = 0; k < DEPTH; k++) wb_write(8'(k));
        check("txfull_size", 32'(tx_size), 32'(DEPTH));
        stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h77;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("txfull_stall_ack", 32'(ack_o), 32'd0);
        end
        tx_clear = 1'b1; tick(1); tx_clear = 1'b0;
        check("tx_clear_size", 32'(tx_size), 32'd0);
        check("tx_clear_no_ack", 32'(ack_o), 32'd0);
        tick(1);
        check("pending_write_ack", 32'(ack_o), 32'd1);
        stb_i = 1'b0; we_i = 1'b0;
        check("pending_write_size", 32'(tx_size), 32'd1);
        cs_begin();
        spi_byte(8'h24, 6, 8, r); check("pending_write_miso", 32'(r), 32'h77);
        cs_end(6);
        wb_read(r); check("pending_write_rx", 32'(r), 32'h24);

        // Reset mid-transfer aborts the byte; a fresh transfer follows
        cs_begin();
        spi_byte(8'hF0, 6, 4, r);
        rstz = 1'b0; tick(2);
        check("midrst_rx_size", 32'(rx_size), 32'd0);
        rstz = 1'b1; tick(8);
        sclk = cpol;
        cs_end(6);
        check("midrst_rx_after", 32'(rx_size), 32'd0);
        cs_begin();
        spi_byte(8'h42, 6, 8, r);
        cs_end(6);
        wb_read(r); check("midrst_fresh_rx", 32'(r), 32'h42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_spi_slave.md
WB_SPI_SLAVE -- requirements
Module: wb_spi_slave

Interface
REQ-001 Parameter: DEPTH, 64, entries in each of the TX and RX byte FIFOs (power of two, 2..32768).
REQ-002 clk  input  1  system clock; all internal logic on posedge clk.
REQ-003 rstz  input  1  reset, asynchronous, active-low.
REQ-004 sclk  input  1  SPI clock from external master, asynchronous to clk.
REQ-005 cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 mosi  input  1  SPI data from master.
REQ-007 miso  output  1  SPI data to master, registered.
REQ-008 cpol  input  1  clock polarity; static while cs_n low.
REQ-009 cpha  input  1  clock phase; static while cs_n low.
REQ-010 tx_clear  input  1  synchronous flush of TX FIFO.
REQ-011 rx_clear  input  1  synchronous flush of RX FIFO.
REQ-012 tx_size  output  16  TX FIFO occupancy.
REQ-013 rx_size  output  16  RX FIFO occupancy.
REQ-014 dat_i  input  8  Wishbone write byte.
REQ-015 dat_o  output  8  Wishbone read byte, valid with ack_o.
REQ-016 we_i  input  1  1 = write TX FIFO, 0 = read RX FIFO.
REQ-017 stb_i  input  1  Wishbone strobe.
REQ-018 ack_o  output  1  Wishbone acknowledge, single-cycle registered pulse.

Function
REQ-019 sclk, cs_n, mosi each pass through a 2-flop synchronizer; sclk edges detected on the synchronized value.
REQ-020 Leading edge = rising if cpol=0, falling if cpol=1; sample edge = leading if cpha=0, trailing if cpha=1; shift edge = the other.
REQ-021 Bytes are MSB-first on both mosi and miso.
REQ-022 Synchronized cs_n fall: bit counter cleared; shift register loaded with TX FIFO head (popped) or 0x00 if TX empty; for cpha=0, miso driven with bit7 on the next clk.
REQ-023 cpha=1: miso updates to the current bit on each shift edge, starting at the first leading edge; cpha=0: miso updates on each shift edge after the first sample.
REQ-024 Each sample edge shifts mosi into the RX shift register and increments a 3-bit counter; on wrap 7->0 the byte is pushed into RX FIFO and the next TX byte (or 0x00 if empty) is loaded.
REQ-025 RX push when RX FIFO full: byte dropped, FIFO contents unchanged.
REQ-026 Synchronized cs_n rise mid-byte: partial RX byte discarded, counter reset, loaded TX byte discarded.
REQ-027 cs_n high: miso = 0, sclk edges ignored.
REQ-028 Latency from sclk pin edge to miso update: at most 4 clk cycles; sclk half-period of at least 6 clk cycles is supported.
REQ-029 Write: stb_i & we_i & !ack_o & TX not full -> push dat_i, ack_o high next cycle; TX full -> no ack (stall) until space.
REQ-030 Read: stb_i & !we_i & !ack_o & RX not empty -> pop, dat_o = head and ack_o high next cycle; RX empty -> stall.
REQ-031 ack_o is never high on two consecutive cycles; peak throughput is one byte per two clk cycles.
REQ-032 tx_clear/rx_clear take priority over same-cycle push/pop on that FIFO; size = 0 the next cycle.
REQ-033 tx_size/rx_size reflect occupancy one cycle after each push/pop/clear, zero-extended to 16 bits.

Reset
REQ-034 rstz low: miso=0, ack_o=0, dat_o=0x00, tx_size=rx_size=0, FIFOs empty, counters and shift registers 0, synchronizers reset to sclk=cpol-idle-agnostic 0, cs_n=1.
REQ-035 Reset asserted mid-transfer aborts the byte with no FIFO push; first cs_n fall after release starts a fresh transfer.

Structure
REQ-036 No shared package needed; the mode decode (sample/shift edge select) stays local.
REQ-037 One sub-module: fifo (8-bit, DEPTH entries, push/pop/clear, full/empty/size), instantiated twice.

Verification
REQ-038 Mode 0, TX preloaded 0xA5,0x3C; master sends 0x5A,0xC3 -> miso bytes 0xA5,0x3C; RX reads 0x5A,0xC3; rx_size 2 -> 0.
REQ-039 All 4 cpol/cpha modes, random 1..31 bytes, sclk half-period 6..16 clk -> RX queue equals master TX, master RX equals slave TX.
REQ-040 TX empty, master clocks 1 byte -> miso byte 0x00, RX receives master byte.
REQ-041 RX full (DEPTH bytes), master sends 0xFF -> rx_size stays DEPTH, first read returns oldest byte.
REQ-042 cs_n rises after 5 bits, then new 1-byte transfer of 0x81 -> RX holds only 0x81.
REQ-043 Write with TX full -> ack_o stays 0; tx_clear asserted -> tx_size 0, pending write then acks.
